// File: rtl/pic_pkg.sv
// Shared definitions for the pic_core_n interrupt controller:
// register map, CTRL bit positions and acknowledge FSM states.
package pic_pkg;

  localparam logic [2:0] ADDR_IMR  = 3'd0;
  localparam logic [2:0] ADDR_TRIG = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_EOI  = 3'd3;
  localparam logic [2:0] ADDR_IRR  = 3'd4;

  localparam int CTRL_VEC_BASE = 0;
  localparam int CTRL_ROT_EN   = 16;
  localparam int CTRL_AEOI     = 17;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_VECTOR = 1'b1
  } pic_state_e;

endpackage

// File: rtl/pic_prio_arbiter_n.sv
// Rotating find-first-set: bit 'ptr' of req is highest priority, wrapping upward.
// Returns whether any request is set and the absolute id of the winner.
module pic_prio_arbiter_n #(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_IRQ);

  logic [NUM_IRQ-1:0] rot;
  logic [ID_W-1:0]    idx;
  logic [ID_W:0]      sum;

  always_comb begin
    // Rotate so the highest-priority channel lands on bit 0.
    rot = NUM_IRQ'({req, req} >> ptr);
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
    sum = {1'b0, idx} + {1'b0, ptr};
    if (sum >= NUM_W) sum = sum - NUM_W;
    valid = |req;
    id    = sum[ID_W-1:0];
  end

endmodule

// File: rtl/pic_core_n.sv
// pic_core_n: synchronous 8259A-style interrupt controller with a flat register port.
// Rotating priority (CTRL bit16 and the rotation pointer) is built only when PIC_ROTATE_EN is defined.
module pic_core_n
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  parameter  int VEC_W   = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_out,
  input  logic               int_ack,
  output logic               vec_valid,
  output logic [VEC_W-1:0]   vec_out
);

  localparam logic [ID_W:0]   NUM_W   = (ID_W+1)'(NUM_IRQ);
  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(NUM_IRQ - 1);

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] i);
    return NUM_IRQ'(1) << i;
  endfunction

  // Distance from the current highest-priority slot; 0 = most urgent.
  function automatic logic [ID_W:0] rank_of(input logic [ID_W-1:0] i, input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    r = {1'b0, i} + NUM_W - {1'b0, p};
    if (r >= NUM_W) r = r - NUM_W;
    return r;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
    return (i == SPUR_ID) ? '0 : i + 1'b1;
  endfunction

  logic [NUM_IRQ-1:0] imr_q, imr_d, trig_q, trig_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, irq_prev_q;
  logic [VEC_W-1:0]   base_q, base_d;
  logic               aeoi_q, aeoi_d;
  pic_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               spur_q, spur_d;
  logic               vec_valid_q, vec_valid_d;
  logic [VEC_W-1:0]   vec_out_q, vec_out_d;

  logic               rot_en;
  logic [ID_W-1:0]    ptr_eff;
  logic               win_valid, isr_valid;
  logic [ID_W-1:0]    win_id, isr_id;
  logic               ctrl_wr, eoi_wr, eoi_hit, aeoi_fire;
  logic [ID_W-1:0]    eoi_id;
  logic [NUM_IRQ-1:0] eoi_mask, ack_set, aeoi_clr;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  pic_prio_arbiter_n #(.NUM_IRQ(NUM_IRQ)) u_req_arb (
    .req   (irr_q & ~imr_q),
    .ptr   (ptr_eff),
    .valid (win_valid),
    .id    (win_id)
  );

  pic_prio_arbiter_n #(.NUM_IRQ(NUM_IRQ)) u_isr_arb (
    .req   (isr_q),
    .ptr   (ptr_eff),
    .valid (isr_valid),
    .id    (isr_id)
  );

  assign int_out = win_valid && !(isr_valid && (rank_of(isr_id, ptr_eff) <= rank_of(win_id, ptr_eff)));

  // EOI decode: out-of-range ids and ids not in service are dropped entirely.
  assign ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign eoi_wr    = cfg_we && (cfg_addr == ADDR_EOI);
  assign eoi_id    = cfg_wdata[ID_W-1:0];
  assign eoi_hit   = eoi_wr && (cfg_wdata < 32'(NUM_IRQ)) && |(isr_q & onehot(eoi_id));
  assign eoi_mask  = eoi_hit ? onehot(eoi_id) : '0;
  assign aeoi_fire = (state_q == ST_VECTOR) && aeoi_q && !spur_q;
  assign aeoi_clr  = aeoi_fire ? onehot(id_q) : '0;

`ifdef PIC_ROTATE_EN
  logic            rot_en_q, rot_en_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    rot_en_d = rot_en_q;
    if (ctrl_wr) rot_en_d = cfg_wdata[CTRL_ROT_EN];
    ptr_d = ptr_q;
    if (rot_en_q && aeoi_fire) ptr_d = next_ptr(id_q);
    if (rot_en_q && eoi_hit)   ptr_d = next_ptr(eoi_id);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rot_en_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      rot_en_q <= rot_en_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rot_en  = rot_en_q;
  assign ptr_eff = rot_en_q ? ptr_q : '0;
`else
  assign rot_en  = 1'b0;
  assign ptr_eff = '0;
`endif

  // Acknowledge handshake: a one-cycle int_ack seen in IDLE produces exactly one
  // vec_valid cycle next; int_ack arriving while that vector is presented is ignored.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    spur_d      = spur_q;
    vec_valid_d = 1'b0;
    vec_out_d   = vec_out_q;
    ack_set     = '0;
    case (state_q)
      ST_IDLE: begin
        if (int_ack) begin
          state_d     = ST_VECTOR;
          vec_valid_d = 1'b1;
          if (int_out) begin
            id_d    = win_id;
            spur_d  = 1'b0;
            ack_set = onehot(win_id);
          end else begin
            id_d   = SPUR_ID;
            spur_d = 1'b1;
          end
          vec_out_d = base_q + VEC_W'(id_d);
        end
      end
      ST_VECTOR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imr_d  = imr_q;
    trig_d = trig_q;
    base_d = base_q;
    aeoi_d = aeoi_q;
    if (cfg_we && (cfg_addr == ADDR_IMR))  imr_d  = cfg_wdata[NUM_IRQ-1:0];
    if (cfg_we && (cfg_addr == ADDR_TRIG)) trig_d = cfg_wdata[NUM_IRQ-1:0];
    if (ctrl_wr) begin
      base_d = cfg_wdata[CTRL_VEC_BASE +: VEC_W];
      aeoi_d = cfg_wdata[CTRL_AEOI];
    end
    // A fresh edge is OR'd in after the ack clear so it is never lost.
    irr_d = (trig_q & ((irr_q & ~ack_set) | (irq_in & ~irq_prev_q))) | (~trig_q & irq_in);
    isr_d = (isr_q & ~eoi_mask & ~aeoi_clr) | ack_set;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_IMR:  cfg_rdata[NUM_IRQ-1:0] = imr_q;
      ADDR_TRIG: cfg_rdata[NUM_IRQ-1:0] = trig_q;
      ADDR_CTRL: begin
        cfg_rdata[CTRL_VEC_BASE +: VEC_W] = base_q;
        cfg_rdata[CTRL_ROT_EN]            = rot_en;
        cfg_rdata[CTRL_AEOI]              = aeoi_q;
      end
      ADDR_EOI:  cfg_rdata[NUM_IRQ-1:0] = isr_q;
      ADDR_IRR:  cfg_rdata[NUM_IRQ-1:0] = irr_q;
      default:   cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      imr_q      <= '1;
      trig_q     <= '0;
      base_q     <= '0;
      aeoi_q     <= 1'b0;
      irr_q      <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
    end else begin
      imr_q      <= imr_d;
      trig_q     <= trig_d;
      base_q     <= base_d;
      aeoi_q     <= aeoi_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      spur_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      spur_q      <= spur_d;
      vec_valid_q <= vec_valid_d;
      vec_out_q   <= vec_out_d;
    end
  end

  // Reset raised during the vector cycle suppresses the pulse immediately.
  assign vec_valid = vec_valid_q && !reset;
  assign vec_out   = vec_out_q;

endmodule
